// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared constants, types and helpers for the HD44780 text sequencer.
//   - HD44780 power-up command bytes and DDRAM row base addresses
//   - per-byte sequencer state enum and the debug struct exported by the top
//   - helpers: init step -> command byte, row -> base address, address width
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;  // increment, no shift

    localparam logic [7:0] LCD_ROW0_ADDR = 8'h80;
    localparam logic [7:0] LCD_ROW1_ADDR = 8'hC0;
    localparam logic [7:0] LCD_ROW2_ADDR = 8'h94;
    localparam logic [7:0] LCD_ROW3_ADDR = 8'hD4;

    localparam int INIT_STEPS = 4;

    // ISSUE encodes as 0 so the reset state is the first init byte.
    typedef enum logic [2:0] {
        ISSUE = 3'd0,
        WAIT  = 3'd1,
        DELAY = 3'd2,
        NEXT  = 3'd3,
        IDLE  = 3'd4
    } state_t;

    typedef struct packed {
        state_t state;
        logic   dirty;
        logic   init_phase;
    } dbg_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    return LCD_CMD_FUNCSET;
            2'd1:    return LCD_CMD_DISP_ON;
            2'd2:    return LCD_CMD_CLEAR;
            default: return LCD_CMD_ENTRY;
        endcase
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] row);
        case (row)
            2'd0:    return LCD_ROW0_ADDR;
            2'd1:    return LCD_ROW1_ADDR;
            2'd2:    return LCD_ROW2_ADDR;
            default: return LCD_ROW3_ADDR;
        endcase
    endfunction

    // A 1x1 panel still needs a 1-bit address bus.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_text_engine_if.sv
// ---------------------------------------------------------------------------
// Interfaces of lcd_text_engine.
//
// lcd_host_if  : host side. Buffer write port (wr_en/wr_addr/wr_data, one
//                write per cycle, no back-pressure), single-cycle refresh
//                request, and the ready/busy status returned by the engine.
//                master = host logic, slave = engine.
//
// lcd_byte_if  : byte transfer to the lcd_controller.
//                Handshake: the engine raises start together with a stable
//                data/rs pair and holds all three until it samples done=1 on
//                a rising edge; on that same edge start drops. done is only
//                meaningful while start is high and is ignored otherwise.
//                master = engine, slave = controller.
// ---------------------------------------------------------------------------
interface lcd_host_if #(
    parameter int AW = 5
) ();
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          refresh;
    logic          ready;
    logic          busy;

    modport master (output wr_en, output wr_addr, output wr_data, output refresh,
                    input ready, input busy);
    modport slave  (input wr_en, input wr_addr, input wr_data, input refresh,
                    output ready, output busy);
endinterface

interface lcd_byte_if ();
    logic [7:0] data;
    logic       rs;
    logic       start;
    logic       done;

    modport master (output data, output rs, output start, input done);
    modport slave  (input data, input rs, input start, output done);
endinterface

// File: rtl/lcd_char_buffer.sv
// ---------------------------------------------------------------------------
// lcd_char_buffer
// ROWS*COLS x 8 character register file, cleared to spaces on reset.
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data : write port; out-of-range addresses are dropped
//   wr_accept    : combinational pulse, high when this cycle's write lands
//   rd_addr/rd_data : combinational read port (out-of-range reads a space)
// ---------------------------------------------------------------------------
module lcd_char_buffer #(
    parameter int ROWS = 2,
    parameter int COLS = 16,
    parameter int AW   = 5
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_accept,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam int NCHAR = ROWS * COLS;
    // NCHAR <= 2**AW, so one extra bit holds it without truncation.
    localparam logic [AW:0] NCHAR_V = (AW + 1)'(NCHAR);

    logic [7:0] mem [NCHAR];

    assign wr_accept = wr_en && ({1'b0, wr_addr} < NCHAR_V);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NCHAR; i++) begin
                mem[i] <= 8'h20;
            end
        end else if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = 8'h20;
        if ({1'b0, rd_addr} < NCHAR_V) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/lcd_text_engine.sv
// ---------------------------------------------------------------------------
// lcd_text_engine
// HD44780 text sequencer for a ROWS x COLS panel. After reset it sends the
// four init commands once, then sends whole frames (row address command
// followed by COLS characters, for each row) on a refresh request or, with
// AUTO_REFRESH, whenever the character buffer has been written.
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   host         : lcd_host_if.slave  - buffer writes, refresh, ready/busy
//   lcd          : lcd_byte_if.master - byte/RS with start/done handshake
//   dbg          : sequencer state, dirty flag, init-phase flag
// ---------------------------------------------------------------------------
module lcd_text_engine
    import lcd_pkg::*;
#(
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int DLY_CYCLES   = 100000,
    parameter int AUTO_REFRESH = 1
) (
    input  logic iCLK,
    input  logic iRST_N,
    lcd_host_if.slave  host,
    lcd_byte_if.master lcd,
    output dbg_t dbg
);

    localparam int NCHAR = ROWS * COLS;
    localparam int AW    = addr_width(NCHAR);
    localparam int CW    = $clog2(DLY_CYCLES + 1);
    // The column counter doubles as the init step index, so it needs >= 2 bits.
    localparam int COLW  = ($clog2(COLS + 1) < 2) ? 2 : $clog2(COLS + 1);

    localparam logic [CW-1:0]   DLY_LAST  = CW'(DLY_CYCLES - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(COLS);
    localparam logic [COLW-1:0] INIT_LAST = COLW'(INIT_STEPS - 1);
    localparam logic [1:0]      ROW_LAST  = 2'(ROWS - 1);

    state_t          state_q, state_d;
    logic [1:0]      row_q;
    logic [COLW-1:0] col_q;     // 0 = row command slot, 1..COLS = characters
    logic [CW-1:0]   dly_q;
    logic            ready_q;
    logic            dirty_q;
    logic [7:0]      data_q;
    logic            rs_q;
    logic            start_q;

    logic            is_init;
    logic            last_byte;
    logic            frame_start;
    logic            busy;
    logic [7:0]      byte_d;
    logic            rs_d;
    int              rd_idx;
    logic [AW-1:0]   rd_addr;
    logic [7:0]      rd_data;
    logic            wr_accept;

    lcd_char_buffer #(
        .ROWS (ROWS),
        .COLS (COLS),
        .AW   (AW)
    ) u_buf (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .wr_en     (host.wr_en),
        .wr_addr   (host.wr_addr),
        .wr_data   (host.wr_data),
        .wr_accept (wr_accept),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Byte selection for the current slot. The buffer is read combinationally
    // and sampled only in ISSUE, so a write landing on that same edge is seen
    // by the next frame instead (dirty covers it).
    always_comb begin
        is_init   = !ready_q;
        rd_idx    = 32'(row_q) * COLS + 32'(col_q) - 1;
        rd_addr   = rd_idx[AW-1:0];
        byte_d    = 8'h00;
        rs_d      = 1'b0;
        last_byte = 1'b0;
        if (is_init) begin
            byte_d    = init_cmd(col_q[1:0]);
            last_byte = (col_q == INIT_LAST);
        end else if (col_q == '0) begin
            byte_d = row_base(row_q);
        end else begin
            byte_d    = rd_data;
            rs_d      = 1'b1;
            last_byte = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
    end

    always_comb begin
        frame_start = (state_q == IDLE) && ready_q &&
                      (host.refresh || ((AUTO_REFRESH != 0) && dirty_q));
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE: state_d = WAIT;
            WAIT:  if (lcd.done) state_d = DELAY;
            DELAY: if (dly_q == DLY_LAST) state_d = NEXT;
            NEXT:  state_d = last_byte ? IDLE : ISSUE;
            IDLE:  if (frame_start) state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: slot counters, delay counter, flags, bus outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            row_q   <= 2'd0;
            col_q   <= '0;
            dly_q   <= '0;
            ready_q <= 1'b0;
            dirty_q <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            // A write on the frame-start edge must not be lost: set beats clear.
            if (wr_accept) begin
                dirty_q <= 1'b1;
            end else if (frame_start) begin
                dirty_q <= 1'b0;
            end

            case (state_q)
                ISSUE: begin
                    data_q  <= byte_d;
                    rs_q    <= rs_d;
                    start_q <= 1'b1;
                end
                WAIT: begin
                    if (lcd.done) start_q <= 1'b0;
                end
                DELAY: begin
                    dly_q <= (dly_q == DLY_LAST) ? '0 : dly_q + 1'b1;
                end
                NEXT: begin
                    if (last_byte) begin
                        row_q   <= 2'd0;
                        col_q   <= '0;
                        ready_q <= 1'b1;
                    end else if (!is_init && (col_q == COL_LAST)) begin
                        row_q <= row_q + 2'd1;
                        col_q <= '0;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy           = (state_q != IDLE);
        dbg            = '0;
        dbg.state      = state_q;
        dbg.dirty      = dirty_q;
        dbg.init_phase = !ready_q;
    end

    assign host.ready = ready_q;
    assign host.busy  = busy;
    assign lcd.data   = data_q;
    assign lcd.rs     = rs_q;
    assign lcd.start  = start_q;

endmodule

// File: tb/tb_lcd_text_engine.sv
// ---------------------------------------------------------------------------
// tb_lcd_text_engine
// Two engines: A (2x16, auto refresh) and B (3x10, refresh only), both with a
// 4-cycle settle delay. Each has a controller responder that logs every
// transferred {rs,data} and answers done a programmable number of cycles
// after start. Expected byte streams come from a character-array model of
// the panel contents and the frame layout rules.
// ---------------------------------------------------------------------------
module tb_lcd_text_engine;
    import lcd_pkg::*;

    localparam int DLY = 4;
    localparam int NA  = 32;   // 2 x 16
    localparam int NB  = 30;   // 3 x 10

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    dbg_t dbg_a, dbg_b;

    lcd_host_if #(.AW(5)) host_a ();
    lcd_host_if #(.AW(5)) host_b ();
    lcd_byte_if lcd_a ();
    lcd_byte_if lcd_b ();

    lcd_text_engine #(.COLS(16), .ROWS(2), .DLY_CYCLES(DLY), .AUTO_REFRESH(1)) dut_a (
        .iCLK(clk), .iRST_N(rst_a), .host(host_a), .lcd(lcd_a), .dbg(dbg_a));

    lcd_text_engine #(.COLS(10), .ROWS(3), .DLY_CYCLES(DLY), .AUTO_REFRESH(0)) dut_b (
        .iCLK(clk), .iRST_N(rst_b), .host(host_b), .lcd(lcd_b), .dbg(dbg_b));

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] bases [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};
    logic [7:0] ref_a [NA];
    logic [7:0] ref_b [NB];
    logic [8:0] exp_a [$];
    logic [8:0] exp_b [$];

    // ---------------- controller responders ----------------
    int         resp_dly_a = 3;
    logic [8:0] got_a [$];
    int         wait_a [$];
    int         dlyc_a [$];
    int         stable_err_a = 0;
    bit         act_a = 0;
    int         cnt_a = 0;
    int         dcnt_a = 0;
    logic [8:0] cur_a;

    always @(negedge clk) begin
        if (!rst_a) begin
            act_a = 0; cnt_a = 0; dcnt_a = 0;
            lcd_a.done = 1'b0;
        end else begin
            if (dbg_a.state == DELAY) dcnt_a++;
            if (dbg_a.state == NEXT) begin
                dlyc_a.push_back(dcnt_a);
                dcnt_a = 0;
            end
            if (lcd_a.done) begin
                lcd_a.done = 1'b0;
                act_a = 0;
                wait_a.push_back(cnt_a);
            end else if (lcd_a.start) begin
                if (!act_a) begin
                    act_a = 1; cnt_a = 0;
                    cur_a = {lcd_a.rs, lcd_a.data};
                    got_a.push_back(cur_a);
                end else if ({lcd_a.rs, lcd_a.data} !== cur_a) begin
                    stable_err_a++;
                end
                cnt_a++;
                if (cnt_a >= resp_dly_a) lcd_a.done = 1'b1;
            end
        end
    end

    logic [8:0] got_b [$];
    bit         act_b = 0;
    int         cnt_b = 0;

    always @(negedge clk) begin
        if (!rst_b) begin
            act_b = 0; cnt_b = 0;
            lcd_b.done = 1'b0;
        end else if (lcd_b.done) begin
            lcd_b.done = 1'b0;
            act_b = 0;
        end else if (lcd_b.start) begin
            if (!act_b) begin
                act_b = 1; cnt_b = 0;
                got_b.push_back({lcd_b.rs, lcd_b.data});
            end
            cnt_b++;
            if (cnt_b >= 2) lcd_b.done = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame layout: per row, the row address command then every character.
    // ov_addr >= 0 substitutes ov_val for that character (value already sent).
    task automatic add_frame_a(input int ov_addr, input logic [7:0] ov_val);
        for (int r = 0; r < 2; r++) begin
            exp_a.push_back({1'b0, bases[r]});
            for (int c = 0; c < 16; c++) begin
                exp_a.push_back({1'b1, (r * 16 + c == ov_addr) ? ov_val : ref_a[r * 16 + c]});
            end
        end
    endtask

    task automatic add_frame_b();
        for (int r = 0; r < 3; r++) begin
            exp_b.push_back({1'b0, bases[r]});
            for (int c = 0; c < 10; c++) exp_b.push_back({1'b1, ref_b[r * 10 + c]});
        end
    endtask

    task automatic add_init_a();
        exp_a.push_back(9'h038); exp_a.push_back(9'h00C);
        exp_a.push_back(9'h001); exp_a.push_back(9'h006);
    endtask

    task automatic compare_a(input string tag);
        chk({tag, "_count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (i < got_a.size()) ? 32'(got_a[i]) : 32'hDEAD, 32'(exp_a[i]));
        end
        got_a.delete();
        exp_a.delete();
    endtask

    task automatic compare_b(input string tag);
        chk({tag, "_count"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (i < got_b.size()) ? 32'(got_b[i]) : 32'hDEAD, 32'(exp_b[i]));
        end
        got_b.delete();
        exp_b.delete();
    endtask

    task automatic wr_a(input int addr, input logic [7:0] d);
        host_a.wr_en = 1'b1; host_a.wr_addr = addr[4:0]; host_a.wr_data = d;
        @(negedge clk);
        host_a.wr_en = 1'b0;
        if (addr < NA) ref_a[addr] = d;
    endtask

    task automatic wr_b(input int addr, input logic [7:0] d);
        host_b.wr_en = 1'b1; host_b.wr_addr = addr[4:0]; host_b.wr_data = d;
        @(negedge clk);
        host_b.wr_en = 1'b0;
        if (addr < NB) ref_b[addr] = d;
    endtask

    // Waits until the engine has stayed idle for 5 consecutive cycles.
    task automatic wait_quiet(input int which, input string tag);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 5000 && quiet < 5; i++) begin
            @(negedge clk);
            if ((which == 0) ? host_a.busy : host_b.busy) quiet = 0;
            else quiet++;
        end
        chk({tag, "_quiet"}, quiet, 5);
    endtask

    task automatic wait_got_a(input int n, input string tag);
        for (int i = 0; i < 2000 && got_a.size() < n; i++) @(negedge clk);
        chk(tag, got_a.size() >= n, 1);
    endtask

    task automatic count_bad(input string tag, input int exp_val, input int which_q);
        int bad;
        bad = 0;
        if (which_q == 0) begin
            foreach (wait_a[i]) if (wait_a[i] != exp_val) bad++;
        end else begin
            foreach (dlyc_a[i]) if (dlyc_a[i] != exp_val) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] old0, n0, c;
        int         a;
        bit         seen_ready;

        for (int i = 0; i < NA; i++) ref_a[i] = 8'h20;
        for (int i = 0; i < NB; i++) ref_b[i] = 8'h20;
        host_a.wr_en = 0; host_a.wr_addr = '0; host_a.wr_data = '0; host_a.refresh = 0;
        host_b.wr_en = 0; host_b.wr_addr = '0; host_b.wr_data = '0; host_b.refresh = 0;
        rst_a = 0; rst_b = 0;
        repeat (3) @(negedge clk);

        chk("rst_ready", host_a.ready, 0);
        chk("rst_busy", host_a.busy, 1);
        chk("rst_start", lcd_a.start, 0);
        chk("rst_data", lcd_a.data, 0);
        chk("rst_rs", lcd_a.rs, 0);
        chk("rst_dirty", dbg_a.dirty, 0);

        rst_a = 1; rst_b = 1;
        @(negedge clk);
        // refresh before ready must be ignored by B
        host_b.refresh = 1'b1;
        @(negedge clk);
        host_b.refresh = 1'b0;

        // ---- A init ----
        seen_ready = 0;
        for (int i = 0; i < 400 && !seen_ready; i++) begin
            @(negedge clk);
            if (host_a.ready) seen_ready = 1;
        end
        chk("a_init_ready", seen_ready, 1);
        chk("a_ready_after_4th_next", dlyc_a.size(), 4);
        chk("a_init_busy_low", host_a.busy, 0);
        count_bad("a_init_wait_len", 3, 0);
        count_bad("a_init_delay_len", DLY, 1);
        add_init_a();
        compare_a("a_init");
        repeat (30) @(negedge clk);
        chk("a_no_frame_after_init", got_a.size(), 0);
        chk("a_idle_busy", host_a.busy, 0);

        // ---- "Hi": second write lands on the frame-start edge -> two frames ----
        wr_a(0, 8'h48);
        wr_a(1, 8'h69);
        add_frame_a(-1, 8'h00);
        add_frame_a(-1, 8'h00);
        wait_quiet(0, "a_hi");
        compare_a("a_hi");
        chk("a_hi_busy", host_a.busy, 0);

        // ---- slow controller: done after 20 cycles ----
        resp_dly_a = 20;
        wait_a.delete(); dlyc_a.delete();
        a = $urandom_range(0, NA - 1);
        c = 8'($urandom_range(33, 126));
        wr_a(a, c);
        add_frame_a(-1, 8'h00);
        wait_quiet(0, "a_slow");
        compare_a("a_slow");
        chk("a_slow_wait_count", wait_a.size(), 34);
        count_bad("a_slow_wait_len", 20, 0);
        chk("a_slow_delay_count", dlyc_a.size(), 34);
        count_bad("a_slow_delay_len", DLY, 1);
        chk("a_slow_stable", stable_err_a, 0);
        resp_dly_a = 3;

        // ---- mid-frame writes: addr0 already sent, row 1 not yet sent ----
        a = $urandom_range(2, 15);
        wr_a(a, 8'($urandom_range(33, 126)));
        wait_got_a(2, "a_mid_progress");
        old0 = ref_a[0];
        n0 = 8'($urandom_range(33, 126));
        if (n0 == old0) n0 = n0 + 8'd1;
        wr_a(0, n0);
        wr_a(16 + $urandom_range(0, 15), 8'($urandom_range(33, 126)));
        add_frame_a(0, old0);
        add_frame_a(-1, 8'h00);
        wait_quiet(0, "a_mid");
        compare_a("a_mid");
        chk("a_mid_dirty_clear", dbg_a.dirty, 0);

        // ---- B: refresh before ready ignored; range check; refresh-only ----
        wait_quiet(1, "b_init");
        exp_b.push_back(9'h038); exp_b.push_back(9'h00C);
        exp_b.push_back(9'h001); exp_b.push_back(9'h006);
        compare_b("b_init");
        chk("b_ready", host_b.ready, 1);
        wr_b(30, 8'h58);
        wr_b(31, 8'h59);
        chk("b_bad_addr_no_dirty", dbg_b.dirty, 0);
        for (int k = 0; k < 3; k++) wr_b($urandom_range(0, NB - 1), 8'($urandom_range(33, 126)));
        chk("b_dirty_set", dbg_b.dirty, 1);
        repeat (40) @(negedge clk);
        chk("b_no_auto_frame", got_b.size(), 0);
        chk("b_idle_busy", host_b.busy, 0);
        host_b.refresh = 1'b1;
        @(negedge clk);
        host_b.refresh = 1'b0;
        add_frame_b();
        for (int i = 0; i < 2000 && got_b.size() < 5; i++) @(negedge clk);
        host_b.refresh = 1'b1;
        @(negedge clk);
        host_b.refresh = 1'b0;
        chk("b_dirty_cleared", dbg_b.dirty, 0);
        wait_quiet(1, "b_frame");
        repeat (30) @(negedge clk);
        compare_b("b_frame");

        // ---- A reset mid-frame ----
        wr_a($urandom_range(0, NA - 1), 8'($urandom_range(33, 126)));
        wait_got_a(5, "a_rst_progress");
        #2 rst_a = 1'b0;
        #1;
        chk("mid_rst_ready", host_a.ready, 0);
        chk("mid_rst_busy", host_a.busy, 1);
        chk("mid_rst_start", lcd_a.start, 0);
        chk("mid_rst_data", lcd_a.data, 0);
        chk("mid_rst_rs", lcd_a.rs, 0);
        chk("mid_rst_dirty", dbg_a.dirty, 0);
        repeat (2) @(negedge clk);
        got_a.delete(); exp_a.delete(); wait_a.delete(); dlyc_a.delete();
        for (int i = 0; i < NA; i++) ref_a[i] = 8'h20;
        rst_a = 1'b1;
        wait_quiet(0, "a_reinit");
        add_init_a();
        compare_a("a_reinit");
        host_a.refresh = 1'b1;
        @(negedge clk);
        host_a.refresh = 1'b0;
        add_frame_a(-1, 8'h00);
        wait_quiet(0, "a_blank");
        compare_a("a_blank");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
